// File: rtl/obstacle_spawner.sv
// Frame-paced obstacle scheduler: waits a shrinking, LFSR-randomised number of frame ticks
// between spawn requests and holds each request until the obstacle slot is free.
module obstacle_spawner #(
  parameter int unsigned InitialGap  = 60,
  parameter int unsigned MinGap      = 40,
  parameter int unsigned MinGapFloor = 16,
  parameter int unsigned GapBits     = 5,
  parameter logic [15:0] Seed        = 16'hACE1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       next_frame_i,
  input  logic       busy_i,
  output logic       spawn_o,
  output logic [1:0] rand_o,
  output logic [7:0] spawn_count_o
);

  localparam int unsigned LfsrW   = 16;
  localparam int unsigned GapW    = 10;
  localparam int unsigned MinGapW = 8;
  localparam int unsigned CountW  = 8;
  localparam logic [LfsrW-1:0]  LfsrTaps = 16'hB400;
  localparam logic [CountW-1:0] CountMax = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [LfsrW-1:0]     lfsr_q;
  logic [GapW-1:0]      gap_q, gap_d, gap_load;
  logic [MinGapW-1:0]   mingap_q, mingap_d;
  logic [1:0]           rand_d;
  logic [CountW-1:0]    count_d;
  logic                 spawn_d;

  // Galois LFSR, free-running whenever out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : LfsrW'(0));
    end
  end

  assign gap_load = GapW'(mingap_q) + GapW'(lfsr_q[GapBits-1:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      gap_q         <= '0;
      mingap_q      <= MinGapW'(MinGap);
      spawn_o       <= 1'b0;
      rand_o        <= '0;
      spawn_count_o <= '0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      mingap_q      <= mingap_d;
      spawn_o       <= spawn_d;
      rand_o        <= rand_d;
      spawn_count_o <= count_d;
    end
  end

  // Next-state and next-output logic; abort (enable low) outranks delivery
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    mingap_d = mingap_q;
    rand_d   = rand_o;
    count_d  = spawn_count_o;

    unique case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          gap_d    = GapW'(InitialGap);
          count_d  = '0;
          mingap_d = MinGapW'(MinGap);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (next_frame_i) begin
          if (gap_q == GapW'(1)) begin
            state_d = S_REQ;
            rand_d  = lfsr_q[1:0];
          end else begin
            gap_d = gap_q - GapW'(1);
          end
        end
      end
      S_REQ: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (next_frame_i && !busy_i) begin
          state_d = S_WAIT;
          gap_d   = gap_load;
          if (spawn_count_o != CountMax) begin
            count_d = spawn_count_o + CountW'(1);
          end
          // Difficulty ramps every 8th delivery until the floor is reached
          if ((spawn_count_o[2:0] == 3'b111) && (mingap_q > MinGapW'(MinGapFloor))) begin
            mingap_d = mingap_q - MinGapW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    spawn_d = (state_d == S_REQ);
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Randomised self-checking bench for obstacle_spawner against a frame-level
// scheduling model (gap countdown, difficulty ramp, saturating count).
module tb_obstacle_spawner;

  localparam int unsigned InitialGap  = 60;
  localparam int unsigned MinGap      = 40;
  localparam int unsigned MinGapFloor = 16;
  localparam int unsigned GapBits     = 5;
  localparam logic [15:0] Seed        = 16'hACE1;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       enable_i = 1'b0;
  logic       next_frame_i = 1'b0;
  logic       busy_i = 1'b0;
  logic       spawn_o;
  logic [1:0] rand_o;
  logic [7:0] spawn_count_o;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_lfsr;
  logic [15:0] l_edge;
  logic [1:0]  m_rand;
  int          m_mingap;
  int          m_count;
  int          m_gap;

  obstacle_spawner #(
    .InitialGap (InitialGap),
    .MinGap     (MinGap),
    .MinGapFloor(MinGapFloor),
    .GapBits    (GapBits),
    .Seed       (Seed)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .enable_i     (enable_i),
    .next_frame_i (next_frame_i),
    .busy_i       (busy_i),
    .spawn_o      (spawn_o),
    .rand_o       (rand_o),
    .spawn_count_o(spawn_count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // One clock; l_edge is the LFSR value the DUT saw on this edge
  task automatic step();
    l_edge = m_lfsr;
    @(posedge clk_i);
    if (rst_ni) m_lfsr = lfsr_next(m_lfsr);
    #1;
  endtask

  task automatic frame(input int idle);
    for (int i = 0; i < idle; i++) step();
    next_frame_i = 1'b1;
    step();
    next_frame_i = 1'b0;
  endtask

  task automatic run_to_spawn(input int g, input int idle, input string name);
    int early;
    early = 0;
    for (int i = 1; i <= g; i++) begin
      busy_i = 1'($urandom_range(0, 1));
      frame(idle);
      if (i < g && spawn_o !== 1'b0) early++;
    end
    busy_i = 1'b0;
    m_rand = l_edge[1:0];
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL %s_early: spawn_o rose %0d ticks early, required 0 (gap %0d)", name, early, g);
    end
    checks++;
    if (spawn_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_rise: spawn_o=%b after %0d ticks, required 1", name, spawn_o, g);
    end
    checks++;
    if (rand_o !== m_rand) begin
      failures++;
      $display("FAIL %s_rand: rand_o=%0d, required %0d", name, rand_o, m_rand);
    end
  endtask

  task automatic deliver(input int nbusy, input int idle, input string name);
    for (int k = 0; k < nbusy; k++) begin
      busy_i = 1'b1;
      frame(idle);
      checks++;
      if (spawn_o !== 1'b1 || rand_o !== m_rand) begin
        failures++;
        $display("FAIL %s_hold: spawn_o=%b rand_o=%0d, required 1 and %0d", name, spawn_o, rand_o, m_rand);
      end
    end
    busy_i = 1'b0;
    frame(idle);
    m_gap = m_mingap + int'(l_edge[GapBits-1:0]);
    if ((m_count % 8) == 7 && m_mingap > int'(MinGapFloor)) m_mingap--;
    if (m_count < 255) m_count++;
    checks++;
    if (spawn_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_fall: spawn_o=%b after delivery, required 0", name, spawn_o);
    end
    checks++;
    if (spawn_count_o !== 8'(m_count)) begin
      failures++;
      $display("FAIL %s_count: spawn_count_o=%0d, required %0d", name, spawn_count_o, m_count);
    end
  endtask

  task automatic test_reset();
    int bad_spawn;
    rst_ni = 1'b0;
    enable_i = 1'b0;
    m_lfsr = Seed;
    repeat (4) @(posedge clk_i);
    #1;
    checks++;
    if (spawn_o !== 1'b0 || rand_o !== 2'd0 || spawn_count_o !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: spawn=%b rand=%0d count=%0d, required 0 0 0", spawn_o, rand_o, spawn_count_o);
    end
    checks++;
    if (dut.lfsr_q !== Seed) begin
      failures++;
      $display("FAIL reset_lfsr: lfsr=%h, required %h", dut.lfsr_q, Seed);
    end
    rst_ni = 1'b1;
    bad_spawn = 0;
    for (int t = 0; t < 100; t++) begin
      frame(2);
      if (spawn_o !== 1'b0) bad_spawn++;
      checks++;
      if (dut.lfsr_q !== m_lfsr) begin
        failures++;
        $display("FAIL idle_lfsr: tick %0d lfsr=%h, required %h", t, dut.lfsr_q, m_lfsr);
      end
    end
    checks++;
    if (bad_spawn != 0) begin
      failures++;
      $display("FAIL idle_spawn: spawn_o high on %0d ticks while disabled, required 0", bad_spawn);
    end
  endtask

  task automatic start_game(input string name);
    enable_i = 1'b1;
    next_frame_i = 1'b1;  // tick in the enabling cycle must not count
    step();
    next_frame_i = 1'b0;
    m_count = 0;
    m_mingap = MinGap;
    checks++;
    if (spawn_count_o !== 8'd0 || spawn_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_start: count=%0d spawn=%b, required 0 0", name, spawn_count_o, spawn_o);
    end
  endtask

  task automatic test_first_spawn();
    start_game("first");
    run_to_spawn(InitialGap, 9, "first");
    deliver(0, 9, "first");
  endtask

  task automatic test_back_pressure();
    run_to_spawn(m_gap, 3, "bp");
    deliver(5, 3, "bp");
  endtask

  task automatic test_gap();
    for (int n = 0; n < 6; n++) begin
      run_to_spawn(m_gap, $urandom_range(1, 4), "gap");
      deliver($urandom_range(0, 2), $urandom_range(1, 4), "gap");
    end
  endtask

  task automatic test_difficulty();
    int extra;
    extra = 0;
    while (extra < 3) begin
      run_to_spawn(m_gap, 1, "diff");
      deliver($urandom_range(0, 1), 1, "diff");
      if (m_count == 200) begin
        checks++;
        if (dut.mingap_q !== 8'(m_mingap)) begin
          failures++;
          $display("FAIL diff_mingap200: mingap=%0d, required %0d", dut.mingap_q, m_mingap);
        end
      end
      if (m_count == 255) extra++;
    end
    checks++;
    if (dut.mingap_q !== 8'(MinGapFloor)) begin
      failures++;
      $display("FAIL diff_floor: mingap=%0d, required %0d", dut.mingap_q, MinGapFloor);
    end
    checks++;
    if (spawn_count_o !== 8'd255) begin
      failures++;
      $display("FAIL diff_saturate: count=%0d, required 255", spawn_count_o);
    end
  endtask

  task automatic test_abort();
    int held;
    held = m_count;
    run_to_spawn(m_gap, 2, "abort");
    enable_i = 1'b0;
    next_frame_i = 1'b1;
    busy_i = 1'b0;
    step();
    next_frame_i = 1'b0;
    checks++;
    if (spawn_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_drop: spawn_o=%b, required 0", spawn_o);
    end
    checks++;
    if (spawn_count_o !== 8'(held)) begin
      failures++;
      $display("FAIL abort_count: count=%0d, required %0d", spawn_count_o, held);
    end
    for (int i = 0; i < 3; i++) frame(2);
    checks++;
    if (spawn_count_o !== 8'(held) || spawn_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_hold: count=%0d spawn=%b, required %0d 0", spawn_count_o, spawn_o, held);
    end
    start_game("reenable");
    run_to_spawn(InitialGap, 2, "reenable");
    deliver(0, 2, "reenable");
  endtask

  task automatic test_reset_mid_req();
    run_to_spawn(m_gap, 2, "rstreq");
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (spawn_o !== 1'b0) begin
      failures++;
      $display("FAIL rstreq_async: spawn_o=%b before any edge, required 0", spawn_o);
    end
    enable_i = 1'b0;
    m_lfsr = Seed;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (spawn_count_o !== 8'd0 || rand_o !== 2'd0) begin
      failures++;
      $display("FAIL rstreq_clear: count=%0d rand=%0d, required 0 0", spawn_count_o, rand_o);
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (dut.lfsr_q !== m_lfsr) begin
      failures++;
      $display("FAIL rstreq_lfsr: lfsr=%h, required %h", dut.lfsr_q, m_lfsr);
    end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_back_pressure();
    test_gap();
    test_difficulty();
    test_abort();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
